gpio_bus_responder: RTL

//  Memory-mapped GPIO peripheral that serves the processor's load/store bus.
//  - Decodes the bus address, accepts word stores and returns load data.
//  - Drives the 8 output pins and synchronises the 8 input pins.
//  - Latches rising edges on inputs as sticky flags and raises an interrupt request.
//  - Sits beside the memory system; the datapath's address/write-data/write-enable fan out to both.

---
 rtl/gpio_bus_responder_pkg.sv | 17 +
 rtl/sync_chain.sv | 28 ++
 rtl/gpio_bus_responder.sv | 102 ++++++++++
 3 files changed

// File: rtl/gpio_bus_responder_pkg.sv
// Shared definitions for the GPIO bus responder: register offsets and address decode.
package gpio_bus_responder_pkg;

  localparam logic [1:0] OFF_OUT   = 2'd0;
  localparam logic [1:0] OFF_IN    = 2'd1;
  localparam logic [1:0] OFF_EDGE  = 2'd2;
  localparam logic [1:0] OFF_IRQEN = 2'd3;

  localparam int unsigned BUS_W = 32;

  // Block occupies one 16-byte window; only addr[31:4] take part in the match.
  function automatic logic addr_hit(input logic [BUS_W-1:0] addr,
                                    input logic [BUS_W-1:0] base);
    return ((addr ^ base) & 32'hFFFF_FFF0) == '0;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Multibit input synchroniser: STAGES flops in series, synchronous reset to zero.
module sync_chain #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q, stage_d;

  always_comb begin
    stage_d = {stage_q[STAGES-2:0], d_i};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/gpio_bus_responder.sv
// Memory-mapped GPIO: output register, synchronised inputs, sticky rising-edge
// flags with write-one-to-clear, and a per-bit enabled level interrupt.
module gpio_bus_responder
  import gpio_bus_responder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
  parameter int unsigned GPIO_W      = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       addr_i,
  input  logic              wr_en_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o,
  output logic              hit_o,
  input  logic [GPIO_W-1:0] pins_i,
  output logic [GPIO_W-1:0] pins_o,
  output logic              irq_o
);

  logic [GPIO_W-1:0] out_q, out_d;
  logic [GPIO_W-1:0] irqen_q, irqen_d;
  logic [GPIO_W-1:0] edge_q, edge_d;
  logic [GPIO_W-1:0] prev_q, prev_d;
  logic              irq_q, irq_d;

  logic [GPIO_W-1:0] sync;
  logic [GPIO_W-1:0] rise;
  logic [GPIO_W-1:0] clr;
  logic [1:0]        off;
  logic              wr;

  // Byte lanes and upper store bits have no meaning for this block.
  logic unused_bus;
  assign unused_bus = ^{addr_i[1:0], wdata_i};

  sync_chain #(
    .WIDTH  (GPIO_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (pins_i),
    .q_o   (sync)
  );

  assign hit_o = addr_hit(addr_i, BASE_ADDR);
  assign off   = addr_i[3:2];
  assign wr    = wr_en_i & hit_o;
  assign rise  = sync & ~prev_q;

  always_comb begin
    out_d   = out_q;
    irqen_d = irqen_q;
    clr     = '0;
    if (wr) begin
      case (off)
        OFF_OUT:   out_d   = wdata_i[GPIO_W-1:0];
        OFF_IN:    ;
        OFF_EDGE:  clr     = wdata_i[GPIO_W-1:0];
        OFF_IRQEN: irqen_d = wdata_i[GPIO_W-1:0];
      endcase
    end
    // A rising edge in the same cycle as its clear keeps the flag set.
    edge_d = (edge_q & ~clr) | rise;
    prev_d = sync;
    irq_d  = |(edge_q & irqen_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_q   <= '0;
      irqen_q <= '0;
      edge_q  <= '0;
      prev_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      irqen_q <= irqen_d;
      edge_q  <= edge_d;
      prev_q  <= prev_d;
      irq_q   <= irq_d;
    end
  end

  always_comb begin
    rdata_o = '0;
    if (hit_o) begin
      case (off)
        OFF_OUT:   rdata_o = 32'(out_q);
        OFF_IN:    rdata_o = 32'(sync);
        OFF_EDGE:  rdata_o = 32'(edge_q);
        OFF_IRQEN: rdata_o = 32'(irqen_q);
      endcase
    end
  end

  assign pins_o = out_q;
  assign irq_o  = irq_q;

endmodule
